mem_stage: RTL and testbench

//  MEM stage of the 16-bit pipeline; consumes EXE stage outputs (instr, pc, result, wreg_addr, store data, rwe, branch).

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results to WB after one register, and runs SRAM loads/stores
// through a small FSM that stalls upstream until the access has completed.
module mem_stage #(
  parameter int          WAIT_CYCLES = 1,
  parameter int          ADDR_W      = 18,
  parameter logic [3:0]  NO_REG      = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       memi_instr,
  input  logic [15:0]       memi_pc,
  input  logic [15:0]       memi_result,
  input  logic [3:0]        memi_wreg_addr,
  input  logic [15:0]       memi_store_data,
  input  logic [1:0]        memi_rwe,
  input  logic              memi_branch,
  output logic              memo_stall,
  output logic [15:0]       memo_instr,
  output logic [15:0]       memo_pc,
  output logic [3:0]        memo_wreg_addr,
  output logic              memo_wreg_en,
  output logic [15:0]       memo_wdata,
  output logic              memo_branch,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_doe,
  input  logic [15:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [3:0]  wreg_addr;
    logic        wreg_en;
    logic [15:0] wdata;
    logic        branch;
  } wb_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [3:0]  wreg_addr;
    logic        branch;
    logic        is_load;
  } lat_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dout_q, dout_d;
  logic [15:0]         rdata_q, rdata_d;
  lat_t                lat_q, lat_d;
  wb_t                 wb_q, wb_d;
  logic                ce_n, oe_n, we_n, doe, stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    wb_d    = '0;        // bubble unless something retires this edge
    stall   = 1'b1;
    ce_n    = 1'b1;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    doe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (memi_rwe == 2'b00) begin
          stall          = 1'b0;
          wb_d.instr     = memi_instr;
          wb_d.pc        = memi_pc;
          wb_d.wreg_addr = memi_wreg_addr;
          wb_d.wreg_en   = (memi_wreg_addr != NO_REG);
          wb_d.wdata     = memi_result;
          wb_d.branch    = memi_branch;
        end else begin
          addr_d        = ADDR_W'(memi_result);
          dout_d        = memi_store_data;
          lat_d.instr     = memi_instr;
          lat_d.pc        = memi_pc;
          lat_d.wreg_addr = memi_wreg_addr;
          lat_d.branch    = memi_branch;
          lat_d.is_load   = (memi_rwe != 2'b10);
          cnt_d         = CNT_INIT;
          state_d       = (memi_rwe == 2'b10) ? WR_SETUP : RD;
        end
      end
      RD: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        if (cnt_q == 4'd0) begin
          rdata_d = sram_din;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        ce_n    = 1'b0;
        doe     = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        ce_n = 1'b0;
        doe  = 1'b1;
        we_n = 1'b0;
        if (cnt_q == 4'd0) state_d = WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_HOLD: begin
        ce_n    = 1'b0;
        doe     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Retire the latched bundle; the next op only starts once back in IDLE.
        stall          = 1'b0;
        wb_d.instr     = lat_q.instr;
        wb_d.pc        = lat_q.pc;
        wb_d.wreg_addr = lat_q.wreg_addr;
        wb_d.wreg_en   = lat_q.is_load && (lat_q.wreg_addr != NO_REG);
        wb_d.wdata     = lat_q.is_load ? rdata_q : addr_q[15:0];
        wb_d.branch    = lat_q.branch;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
      wb_q    <= wb_d;
    end
  end

  assign memo_stall     = stall;
  assign memo_instr     = wb_q.instr;
  assign memo_pc        = wb_q.pc;
  assign memo_wreg_addr = wb_q.wreg_addr;
  assign memo_wreg_en   = wb_q.wreg_en;
  assign memo_wdata     = wb_q.wdata;
  assign memo_branch    = wb_q.branch;
  assign sram_addr      = addr_q;
  assign sram_dout      = dout_q;
  assign sram_doe       = doe;
  assign sram_ce_n      = ce_n;
  assign sram_oe_n      = oe_n;
  assign sram_we_n      = we_n;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: dut A (WAIT_CYCLES=2) and dut B (WAIT_CYCLES=1),
// each attached to a simple SRAM model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_instr, a_pc, a_result, a_sd;
  logic [3:0]  a_wreg;
  logic [1:0]  a_rwe;
  logic        a_branch;
  logic        a_stall, a_owen, a_obranch, a_doe, a_ce_n, a_oe_n, a_we_n;
  logic [15:0] a_oinstr, a_opc, a_owdata, a_dout, a_din;
  logic [3:0]  a_owreg;
  logic [17:0] a_addr;

  logic [15:0] b_instr, b_pc, b_result, b_sd;
  logic [3:0]  b_wreg;
  logic [1:0]  b_rwe;
  logic        b_branch;
  logic        b_stall, b_owen, b_obranch, b_doe, b_ce_n, b_oe_n, b_we_n;
  logic [15:0] b_oinstr, b_opc, b_owdata, b_dout, b_din;
  logic [3:0]  b_owreg;
  logic [17:0] b_addr;

  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];

  mem_stage #(.WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .memi_instr(a_instr), .memi_pc(a_pc), .memi_result(a_result),
    .memi_wreg_addr(a_wreg), .memi_store_data(a_sd), .memi_rwe(a_rwe),
    .memi_branch(a_branch), .memo_stall(a_stall), .memo_instr(a_oinstr),
    .memo_pc(a_opc), .memo_wreg_addr(a_owreg), .memo_wreg_en(a_owen),
    .memo_wdata(a_owdata), .memo_branch(a_obranch), .sram_addr(a_addr),
    .sram_dout(a_dout), .sram_doe(a_doe), .sram_din(a_din),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n));

  mem_stage #(.WAIT_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .memi_instr(b_instr), .memi_pc(b_pc), .memi_result(b_result),
    .memi_wreg_addr(b_wreg), .memi_store_data(b_sd), .memi_rwe(b_rwe),
    .memi_branch(b_branch), .memo_stall(b_stall), .memo_instr(b_oinstr),
    .memo_pc(b_opc), .memo_wreg_addr(b_owreg), .memo_wreg_en(b_owen),
    .memo_wdata(b_owdata), .memo_branch(b_obranch), .sram_addr(b_addr),
    .sram_dout(b_dout), .sram_doe(b_doe), .sram_din(b_din),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n));

  // Async-read SRAM models; A writes while we_n is low
  assign a_din = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[9:0]] : 16'h0;
  assign b_din = (!b_ce_n && !b_oe_n) ? mem_b[b_addr[9:0]] : 16'h0;

  int a_we_lo = 0, a_doe_hi = 0, a_ce_lo = 0, b_oe_lo = 0;
  always @(negedge clk) begin
    if (!a_we_n) a_we_lo++;
    if (a_doe) a_doe_hi++;
    if (!a_ce_n) a_ce_lo++;
    if (!b_oe_n) b_oe_lo++;
    if (!a_we_n && !a_ce_n) mem_a[a_addr[9:0]] = a_dout;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input logic [1:0] rwe, input logic [15:0] res, input logic [15:0] sd,
                         input logic [3:0] wreg, input logic [15:0] instr, input logic [15:0] pc,
                         input logic br);
    a_rwe = rwe; a_result = res; a_sd = sd; a_wreg = wreg;
    a_instr = instr; a_pc = pc; a_branch = br;
  endtask

  task automatic nop_a();
    drive_a(2'b00, 16'h0, 16'h0, 4'hF, 16'h0, 16'h0, 1'b0);
  endtask

  // Counts stall cycles of dut A, checking that every stalled edge emits a bubble
  task automatic run_a(input string tag, output int n);
    n = 0;
    #1;
    while (a_stall && n < 30) begin
      n++;
      step();
      chk({tag, "_bub_wen"}, 32'(a_owen), 32'd0);
      chk({tag, "_bub_instr"}, 32'(a_oinstr), 32'd0);
      chk({tag, "_bub_br"}, 32'(a_obranch), 32'd0);
    end
  endtask

  initial begin
    int n, w0, d0, c0, o0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 16'h0;
    mem_b[10'h040] = 16'hBEEF;
    rst = 1'b1;
    nop_a();
    b_rwe = 2'b00; b_result = 16'h0; b_sd = 16'h0; b_wreg = 4'hF;
    b_instr = 16'h0; b_pc = 16'h0; b_branch = 1'b0;
    step(); step();
    chk("por_wen", 32'(a_owen), 32'd0);
    chk("por_instr", 32'(a_oinstr), 32'd0);
    chk("por_ce_we_oe", {29'd0, a_ce_n, a_we_n, a_oe_n}, 32'd7);
    chk("por_doe", 32'(a_doe), 32'd0);
    chk("por_addr", 32'(a_addr), 32'd0);
    chk("por_dout", 32'(a_dout), 32'd0);
    chk("por_b_ctl", {29'd0, b_ce_n, b_we_n, b_doe}, 32'd6);
    rst = 1'b0;

    // ALU pass-through
    drive_a(2'b00, 16'h1234, 16'h0, 4'd3, 16'h1111, 16'h0010, 1'b1);
    #1 chk("alu_stall0", 32'(a_stall), 32'd0);
    step();
    chk("alu_wdata", 32'(a_owdata), 32'h1234);
    chk("alu_wen", 32'(a_owen), 32'd1);
    chk("alu_wreg", 32'(a_owreg), 32'd3);
    chk("alu_instr_pc", {a_oinstr, a_opc}, 32'h1111_0010);
    chk("alu_branch", 32'(a_obranch), 32'd1);
    chk("alu_stall1", 32'(a_stall), 32'd0);

    // NO_REG writeback suppressed
    drive_a(2'b00, 16'h7777, 16'h0, 4'hF, 16'h1112, 16'h0012, 1'b0);
    step();
    chk("noreg_wen", 32'(a_owen), 32'd0);
    chk("noreg_wdata", 32'(a_owdata), 32'h7777);

    // Load on B (W=1)
    o0 = b_oe_lo;
    b_rwe = 2'b01; b_result = 16'h0040; b_wreg = 4'd5; b_instr = 16'h2222; b_pc = 16'h0020; b_branch = 1'b1;
    n = 0;
    #1;
    while (b_stall && n < 30) begin n++; step(); end
    chk("ldb_stall", n, 2);
    chk("ldb_addr", 32'(b_addr), 32'h00040);
    chk("ldb_oe_cyc", b_oe_lo - o0, 1);
    chk("ldb_bub_wen", 32'(b_owen), 32'd0);
    b_rwe = 2'b00; b_wreg = 4'hF; b_instr = 16'h0; b_branch = 1'b0;
    step();
    chk("ldb_wdata", 32'(b_owdata), 32'hBEEF);
    chk("ldb_wen_wreg", {a_stall, b_owen, 2'b00, b_owreg}, {1'b0, 1'b1, 2'b00, 4'd5});
    chk("ldb_instr_br", {b_oinstr, 15'd0, b_obranch}, {16'h2222, 16'd1});

    // Store on A (W=2)
    w0 = a_we_lo; d0 = a_doe_hi;
    drive_a(2'b10, 16'h0100, 16'hA5A5, 4'd7, 16'h3333, 16'h0030, 1'b0);
    run_a("st", n);
    chk("st_stall", n, 5);
    chk("st_we_cyc", a_we_lo - w0, 2);
    chk("st_doe_cyc", a_doe_hi - d0, 4);
    chk("st_mem", 32'(mem_a[10'h100]), 32'hA5A5);
    nop_a();
    step();
    chk("st_wen", 32'(a_owen), 32'd0);
    chk("st_instr", 32'(a_oinstr), 32'h3333);

    // rwe=11 is a load
    drive_a(2'b11, 16'h0100, 16'h0, 4'd2, 16'h6666, 16'h0060, 1'b0);
    run_a("ld11", n);
    chk("ld11_stall", n, 3);
    nop_a();
    step();
    chk("ld11_wdata", 32'(a_owdata), 32'hA5A5);
    chk("ld11_wen", 32'(a_owen), 32'd1);

    // Back-to-back store then load, same address
    drive_a(2'b10, 16'h0200, 16'h5A5A, 4'd1, 16'h5555, 16'h0050, 1'b0);
    run_a("bb_st", n);
    chk("bb_st_stall", n, 5);
    c0 = a_ce_lo;
    drive_a(2'b01, 16'h0200, 16'h0, 4'd4, 16'h4444, 16'h0040, 1'b0);
    #1 chk("bb_done_stall", 32'(a_stall), 32'd0);
    step();
    chk("bb_idle_ce", 32'(a_ce_n), 32'd1);
    chk("bb_st_retire", {a_oinstr, 15'd0, a_owen}, {16'h5555, 16'd0});
    run_a("bb_ld", n);
    chk("bb_ld_stall", n, 3);
    chk("bb_ce_cyc", a_ce_lo - c0, 2);
    nop_a();
    step();
    chk("bb_ld_wdata", 32'(a_owdata), 32'h5A5A);
    chk("bb_ld_wen_wreg", {a_owen, a_owreg}, {1'b1, 4'd4});

    // Reset in the middle of a store pulse
    drive_a(2'b10, 16'h0300, 16'h1111, 4'd6, 16'h7777, 16'h0070, 1'b0);
    step(); step();
    chk("rst_pre_we", 32'(a_we_n), 32'd0);
    chk("rst_pre_stall", 32'(a_stall), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_ctl", {28'd0, a_we_n, a_oe_n, a_ce_n, a_doe}, 32'hE);
    chk("rst_memo", {a_oinstr, a_opc}, 32'd0);
    chk("rst_memo2", {a_owdata, 10'd0, a_owreg, a_owen, a_obranch}, 32'd0);
    nop_a();
    step();
    rst = 1'b0;
    #1 chk("rst_stall", 32'(a_stall), 32'd0);
    step();
    chk("rst_after_ctl", {29'd0, a_we_n, a_ce_n, a_doe}, 32'd6);
    chk("rst_after_wen", 32'(a_owen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
